serial_tx_fifo: RTL and testbench



---
 rtl/serial_pkg.sv | 28 ++
 rtl/serial_sync_fifo.sv | 62 ++++++
 rtl/serial_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_serial_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the buffered serial transmitter: parity modes,
// FSM state encoding and frame-length helper.
package serial_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_PAR   = ST_PAR,
        S_STOP  = ST_STOP
    } tx_state_t;

    // Number of bit periods in one frame, start bit through last stop bit.
    function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/serial_sync_fifo.sv
// Single-clock show-ahead FIFO; full is judged before any same-cycle pop,
// so a write into a full FIFO is dropped even if the head leaves that cycle.
module serial_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx_fifo.sv
// Buffered UART-style serializer: write FIFO feeding a start/data/parity/stop
// frame FSM with a baud divider and a registered, idle-high serial line.
module serial_tx_fifo
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic                          WR_EN,
    input  logic [DATA_W-1:0]             WR_DATA,
    output logic                          FULL,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic                          BUSY,
    output logic                          OVERFLOW,
    output logic                          SERIAL_OUT
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic              HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic              ODD_PAR   = (PARITY == PAR_ODD);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              out_d;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic              pop;
    logic              shift_en;
    logic              baud_end;
    logic              fifo_empty;
    logic [DATA_W-1:0] head_data;

    serial_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (CLR),
        .wr_en   (WR_EN),
        .wr_data (WR_DATA),
        .rd_en   (pop),
        .rd_data (head_data),
        .full    (FULL),
        .empty   (fifo_empty),
        .level   (LEVEL)
    );

    assign baud_end = (baud_q == BAUD_LAST);
    assign BUSY     = (state_q != S_IDLE) || !fifo_empty;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        out_d    = SERIAL_OUT;
        pop      = 1'b0;
        shift_en = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_ONE;
        end
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    baud_d  = '0;
                    out_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    out_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            state_d = S_PAR;
                            out_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            out_d   = 1'b1;
                        end
                    end else begin
                        bit_d    = bit_q + BIT_ONE;
                        shift_en = 1'b1;
                        out_d    = shift_q[1];
                    end
                end
            end
            S_PAR: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    out_d   = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next frame when data is waiting.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                            out_d   = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            out_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                        out_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                out_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            SERIAL_OUT <= 1'b1;
            OVERFLOW   <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            SERIAL_OUT <= out_d;
            OVERFLOW   <= OVERFLOW | (WR_EN & FULL);
        end
    end

    // Parity is fixed at load time so later writes cannot affect it.
    always_ff @(posedge CLK) begin
        if (pop) begin
            shift_q <= head_data;
            par_q   <= (^head_data) ^ ODD_PAR;
        end else if (shift_en) begin
            shift_q <= shift_q >> 1;
        end
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: three configurations share one stimulus stream and
// are checked every cycle against a frame-vector/queue model plus literal cases.
module tb_serial_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int NREC  = 100;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       WR_EN = 1'b0;
    logic [7:0] WR_DATA = 8'h00;

    logic       so   [3];
    logic       full [3];
    logic       busy [3];
    logic       ovf  [3];
    logic [2:0] lvl  [3];

    int par_cfg [3] = '{0, 1, 2};
    int stp_cfg [3] = '{1, 1, 2};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    serial_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .CLK(CLK), .CLR(CLR), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .FULL(full[0]),
        .LEVEL(lvl[0]), .BUSY(busy[0]), .OVERFLOW(ovf[0]), .SERIAL_OUT(so[0]));
    serial_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut1 (
        .CLK(CLK), .CLR(CLR), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .FULL(full[1]),
        .LEVEL(lvl[1]), .BUSY(busy[1]), .OVERFLOW(ovf[1]), .SERIAL_OUT(so[1]));
    serial_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut2 (
        .CLK(CLK), .CLR(CLR), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .FULL(full[2]),
        .LEVEL(lvl[2]), .BUSY(busy[2]), .OVERFLOW(ovf[2]), .SERIAL_OUT(so[2]));

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, d, $time, got, exp);
        end
    endtask

    // Model: a queue of payloads and, while a frame is on the wire, the frame
    // as a bit vector plus the cycle offset into it.
    logic [7:0]  m_mem   [3][DEPTH];
    int          m_hd    [3];
    int          m_cnt   [3];
    int          m_t     [3];
    int          m_len   [3];
    bit          m_act   [3];
    bit          m_ovf   [3];
    logic [15:0] m_frame [3];

    function automatic logic [15:0] build_frame(input logic [7:0] data, input int par);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = data;
        if (par != 0) f[9] = (^data) ^ (par == 2);
        return f;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_hd[d]    = 0;
            m_cnt[d]   = 0;
            m_t[d]     = 0;
            m_act[d]   = 1'b0;
            m_ovf[d]   = 1'b0;
            m_frame[d] = '1;
            m_len[d]   = (1 + DW + ((par_cfg[d] != 0) ? 1 : 0) + stp_cfg[d]) * CPB;
        end
    endtask

    task automatic model_step(input int d, input logic wr, input logic [7:0] wd);
        bit full_pre;
        full_pre = (m_cnt[d] == DEPTH);
        if (m_act[d]) begin
            if (m_t[d] == m_len[d] - 1) m_act[d] = 1'b0;
            else m_t[d]++;
        end
        if (!m_act[d] && m_cnt[d] > 0) begin
            m_frame[d] = build_frame(m_mem[d][m_hd[d]], par_cfg[d]);
            m_hd[d]    = (m_hd[d] + 1) % DEPTH;
            m_cnt[d]--;
            m_act[d]   = 1'b1;
            m_t[d]     = 0;
        end
        if (wr && !full_pre) begin
            m_mem[d][(m_hd[d] + m_cnt[d]) % DEPTH] = wd;
            m_cnt[d]++;
        end
        if (wr && full_pre) m_ovf[d] = 1'b1;
    endtask

    task automatic compare_all();
        for (int d = 0; d < 3; d++) begin
            logic exp_so;
            exp_so = m_act[d] ? m_frame[d][m_t[d] / CPB] : 1'b1;
            chk("serial_out", d, 32'(so[d]), 32'(exp_so));
            chk("level", d, 32'(lvl[d]), 32'(m_cnt[d]));
            chk("full", d, 32'(full[d]), 32'(m_cnt[d] == DEPTH));
            chk("busy", d, 32'(busy[d]), 32'(m_act[d] || m_cnt[d] > 0));
            chk("overflow", d, 32'(ovf[d]), 32'(m_ovf[d]));
        end
    endtask

    logic       edge_act = 1'b0;
    logic       wr_s = 1'b0;
    logic [7:0] wd_s = 8'h00;

    always @(posedge CLK) begin
        edge_act <= !CLR;
        wr_s     <= WR_EN;
        wd_s     <= WR_DATA;
    end

    initial begin
        model_reset();
        forever begin
            @(negedge CLK);
            if (CLR) model_reset();
            else if (edge_act) begin
                for (int d = 0; d < 3; d++) model_step(d, wr_s, wd_s);
            end
            compare_all();
        end
    end

    logic       rec_so   [3][NREC];
    logic       rec_busy [3][NREC];
    logic [2:0] rec_lvl  [3][NREC];

    // Write d1, then record n cycles; optionally write d2 so it lands on edge second_at.
    task automatic run_frame(input logic [7:0] d1, input int second_at, input logic [7:0] d2, input int n);
        @(negedge CLK);
        WR_EN   = 1'b1;
        WR_DATA = d1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                rec_so[k][i]   = so[k];
                rec_busy[k][i] = busy[k];
                rec_lvl[k][i]  = lvl[k];
            end
            WR_EN   = (i == second_at - 1);
            WR_DATA = d2;
        end
    endtask

    logic [11:0] exp_bits [3] = '{12'b1111_0100_1010, 12'b1101_0100_1010, 12'b1111_0100_1010};
    int          exp_busy [3] = '{40, 44, 48};
    logic [2:0]  ov_lvl [6];
    logic        ov_full [6];
    logic        ov_flag [6];
    int          exp_ov_lvl [6] = '{1, 1, 2, 3, 4, 4};
    int          rate;

    initial begin
        #2 CLR = 1'b1;
        repeat (3) @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            chk("rst_serial", d, 32'(so[d]), 32'd1);
            chk("rst_level", d, 32'(lvl[d]), 32'd0);
            chk("rst_busy", d, 32'(busy[d]), 32'd0);
        end
        @(posedge CLK);
        #1 CLR = 1'b0;
        repeat (2) @(negedge CLK);

        // Single 0xA5 frame in all three configurations.
        run_frame(8'hA5, -1, 8'h00, 60);
        chk("lat_level", 0, 32'(rec_lvl[0][0]), 32'd1);
        chk("lat_idle", 0, 32'(rec_so[0][0]), 32'd1);
        chk("lat_start", 0, 32'(rec_so[0][1]), 32'd0);
        for (int d = 0; d < 3; d++) begin
            int cnt;
            for (int k = 0; k < 12; k++) begin
                chk("frame_bit", d, 32'(rec_so[d][2 + 4 * k]), 32'(exp_bits[d][k]));
            end
            cnt = 0;
            for (int i = 1; i < 60 && rec_busy[d][i]; i++) cnt++;
            chk("busy_len", d, 32'(cnt), 32'(exp_busy[d]));
        end

        // Burst of six writes from idle: one pop happens early, the sixth overflows.
        @(negedge CLK);
        WR_EN   = 1'b1;
        WR_DATA = 8'h01;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            ov_lvl[i]  = lvl[0];
            ov_full[i] = full[0];
            ov_flag[i] = ovf[0];
            WR_DATA    = 8'(i + 2);
            if (i == 5) WR_EN = 1'b0;
        end
        for (int i = 0; i < 6; i++) chk("burst_level", 0, 32'(ov_lvl[i]), 32'(exp_ov_lvl[i]));
        chk("burst_full_before", 0, 32'(ov_full[3]), 32'd0);
        chk("burst_full", 0, 32'(ov_full[4]), 32'd1);
        chk("burst_ovf_before", 0, 32'(ov_flag[4]), 32'd0);
        chk("burst_ovf", 0, 32'(ov_flag[5]), 32'd1);
        repeat (260) @(negedge CLK);

        // Reset in the middle of the first data bit of 0x3C with 0x11 queued.
        @(negedge CLK);
        WR_EN   = 1'b1;
        WR_DATA = 8'h3C;
        @(negedge CLK);
        WR_DATA = 8'h11;
        @(negedge CLK);
        WR_EN = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre_rst_serial", 0, 32'(so[0]), 32'd0);
        chk("pre_rst_level", 0, 32'(lvl[0]), 32'd1);
        chk("pre_rst_ovf", 0, 32'(ovf[0]), 32'd1);
        @(posedge CLK);
        #1 CLR = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("async_serial", d, 32'(so[d]), 32'd1);
            chk("async_level", d, 32'(lvl[d]), 32'd0);
            chk("async_ovf", d, 32'(ovf[d]), 32'd0);
            chk("async_busy", d, 32'(busy[d]), 32'd0);
        end
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 CLR = 1'b0;
        repeat (40) @(negedge CLK);
        chk("post_rst_quiet", 0, 32'(so[0]), 32'd1);
        chk("post_rst_busy", 0, 32'(busy[0]), 32'd0);

        // Second write lands on the edge that ends dut0's last stop bit.
        run_frame(8'h5A, 41, 8'hC3, NREC);
        chk("edge_wr_idle_serial", 0, 32'(rec_so[0][41]), 32'd1);
        chk("edge_wr_idle_level", 0, 32'(rec_lvl[0][41]), 32'd1);
        chk("edge_wr_idle_busy", 0, 32'(rec_busy[0][41]), 32'd1);
        chk("edge_wr_start", 0, 32'(rec_so[0][42]), 32'd0);
        chk("edge_wr_popped", 0, 32'(rec_lvl[0][42]), 32'd0);
        repeat (60) @(negedge CLK);

        // Random traffic at light, medium and saturating write rates.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            case ((c / 500) % 3)
                0:       rate = 4;
                1:       rate = 15;
                default: rate = 70;
            endcase
            WR_EN   = ($urandom_range(0, 99) < rate);
            WR_DATA = 8'($urandom);
        end
        WR_EN = 1'b0;
        repeat (300) @(negedge CLK);
        chk("drained_busy", 2, 32'(busy[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
